uart_word_writer: RTL and testbench
===================================

UART_WORD_WRITER -- requirements
Module: uart_word_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, FIFO word width; a multiple of 8, minimum 8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; minimum 2.
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 sends byte 0 (bits 7:0) first, 1 sends the top byte first.
REQ-004 SHALL have parameter PARITY, default 0; 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 tx  output  1  serial line; idle high.
REQ-009 fifo_empty  input  1  high when the upstream show-ahead FIFO has no word.
REQ-010 fifo_data  input  DATA_WIDTH  FIFO head word; valid while fifo_empty is low.
REQ-011 fifo_read_en  output  1  one-cycle pop strobe.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 words_sent  output  16  count of fully transmitted words.

Function
REQ-014 Registered FSM SHALL have states IDLE, FETCH, START, DATA, PAR, STOP.
REQ-015 IDLE: fifo_empty low at an edge -> next cycle fifo_read_en=1 and state FETCH; otherwise stay in IDLE with tx=1.
REQ-016 FETCH lasts exactly one cycle: fifo_data captured into the word register on its closing edge; fifo_read_en returns to 0; byte index cleared; state START.
REQ-017 fifo_read_en SHALL be high only in FETCH, so there is exactly one pop per word and never a pop while fifo_empty was high at the IDLE decision edge.
REQ-018 Each bit period SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-019 START: tx=0 for one bit period, then DATA.
REQ-020 DATA: the 8 bits of the current byte SHALL be sent LSB first; after bit 7 go to PAR if PARITY!=0, else STOP.
REQ-021 PAR: tx = XOR of the byte bits (even parity) or its inverse (odd parity) for one bit period, then STOP.
REQ-022 STOP: tx=1 for STOP_BITS bit periods.
REQ-023 At the end of STOP: if the byte index is below DATA_WIDTH/8-1, increment the index and enter START with no idle gap; otherwise increment words_sent and return to IDLE.
REQ-024 Byte order: byte k sent in position k when MSB_FIRST=0; byte (DATA_WIDTH/8-1-k) when MSB_FIRST=1.
REQ-025 words_sent SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Changes on fifo_data or fifo_empty outside FETCH SHALL NOT affect the word in flight.
REQ-027 Back-to-back words: IDLE is held for exactly one cycle between the last stop bit and the next FETCH decision, so the inter-word gap is 2 cycles of idle-high tx.
REQ-028 Frame length SHALL be (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles per byte.
REQ-029 The tx output SHALL be driven from a flop; it SHALL NOT glitch at state transitions.

Reset
REQ-030 rst=0 at an edge SHALL force, on that edge: state IDLE, tx=1, fifo_read_en=0, busy=0, words_sent=0, bit counter 0, byte index 0, word register 0.
REQ-031 Reset mid-frame SHALL abort the frame without completing it; the popped word is discarded and the counter is not incremented.
REQ-032 Reset takes priority over every other event in the same cycle, including fifo_empty falling.
REQ-033 After rst returns high, the first possible fifo_read_en SHALL occur 1 cycle after fifo_empty is seen low.

Verification
REQ-034 DATA_WIDTH=32, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, MSB_FIRST=0; push 0xA1B2C3D4 -> bytes D4,C3,B2,A1; each frame 40 cycles; tx low 160 cycles... wait, continuous frames: 160 cycles total from first start bit; words_sent=1; a single fifo_read_en pulse.
REQ-035 Same as REQ-034 with MSB_FIRST=1 -> byte order A1,B2,C3,D4.
REQ-036 DATA_WIDTH=8, PARITY=2, STOP_BITS=2, CLKS_PER_BIT=4, byte 0x07 -> 0,1,1,1,0,0,0,0,0,P=0,1,1; 48 cycles.
REQ-037 Two words queued back-to-back -> exactly 2 pops; 2-cycle idle gap between words; words_sent=2.
REQ-038 Assert rst=0 in DATA bit 3 of byte 1 -> tx=1 and busy=0 on the next edge; words_sent=0; on release, the next queued word is sent from byte 0.
REQ-039 Preload words_sent to 0xFFFF (force), send one word -> words_sent=0x0000.

Source files
------------

// File: rtl/uart_word_writer.sv
// Drains words from a show-ahead FIFO and serialises them byte by byte as
// 8-bit UART frames with optional parity and one or two stop bits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module uart_word_writer #(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  tx,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(NUM_BYTES - 1);
  localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PAR, STOP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic                    stop_q, stop_d;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [15:0]             words_q, words_d;
  logic                    tx_q, tx_d;
  logic                    rd_q, rd_d;

  logic [BYTE_W-1:0]       byte_sel;
  logic [7:0]              cur_byte;
  logic                    parity_bit;
  logic                    bit_done;

  always_comb begin
    byte_sel   = (MSB_FIRST != 0) ? (LAST_BYTE - byte_q) : byte_q;
    cur_byte   = word_q[{byte_sel, 3'b000} +: 8];
    parity_bit = (PARITY == 2) ? ~(^cur_byte) : ^cur_byte;
    bit_done   = (cnt_q == '0);
  end

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    stop_d  = stop_q;
    words_d = words_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = START;
        cnt_d   = CNT_RELOAD;
        byte_d  = '0;
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PAR: begin
        if (bit_done) begin
          state_d = STOP;
          cnt_d   = CNT_RELOAD;
          stop_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (!bit_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (stop_q != STOP_LAST) begin
          stop_d = 1'b1;
          cnt_d  = CNT_RELOAD;
        end else if (byte_q < LAST_BYTE) begin
          // Next byte of the same word follows with no idle gap.
          byte_d  = byte_q + 1'b1;
          state_d = START;
          cnt_d   = CNT_RELOAD;
        end else begin
          words_d = words_q + 16'd1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line lines up with the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      PAR:     tx_d = parity_bit;
      default: tx_d = 1'b1;
    endcase
    rd_d = (state_d == FETCH);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      // NOTE: the word register is cleared too, so an aborted word never leaks into a later frame.
      word_q  <= '0;
      words_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
      words_q <= words_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      if (state_q == FETCH) word_q <= fifo_data;
    end
  end

  assign tx           = tx_q;
  assign fifo_read_en = rd_q;
  assign busy         = (state_q != IDLE);
  assign words_sent   = words_q;

endmodule

// File: tb/tb_uart_word_writer.sv
// Directed bench for uart_word_writer: three configurations share clk/rst, each fed
// by a small show-ahead FIFO model; tx is traced per cycle and compared to hand-built frames.
module tb_uart_word_writer;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  fifo_empty, rd_en, tx, busy;
  logic [31:0] fd0, fd1;
  logic [7:0]  fd2;
  logic [15:0] ws0, ws1, ws2;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [7:0]  q2[$];
  logic [2:0]  tx_tr[$];
  logic [2:0]  rd_tr[$];
  logic        exp_w[$];

  int checks   = 0;
  int failures = 0;

  uart_word_writer #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx(tx[0]), .fifo_empty(fifo_empty[0]), .fifo_data(fd0),
    .fifo_read_en(rd_en[0]), .busy(busy[0]), .words_sent(ws0));

  uart_word_writer #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .tx(tx[1]), .fifo_empty(fifo_empty[1]), .fifo_data(fd1),
    .fifo_read_en(rd_en[1]), .busy(busy[1]), .words_sent(ws1));

  uart_word_writer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .MSB_FIRST(0), .PARITY(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .tx(tx[2]), .fifo_empty(fifo_empty[2]), .fifo_data(fd2),
    .fifo_read_en(rd_en[2]), .busy(busy[2]), .words_sent(ws2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Data lines carry garbage while empty: it must never reach the wire.
  task automatic refresh();
    fifo_empty[0] = (q0.size() == 0);
    fifo_empty[1] = (q1.size() == 0);
    fifo_empty[2] = (q2.size() == 0);
    fd0 = 32'hDEADBEEF;
    fd1 = 32'hBEEFDEAD;
    fd2 = 8'h5A;
    if (q0.size() != 0) fd0 = q0[0];
    if (q1.size() != 0) fd1 = q1[0];
    if (q2.size() != 0) fd2 = q2[0];
  endtask

  // One clock: pop where the closing edge ended a FETCH cycle, then record the lines.
  task automatic tick();
    logic [2:0] pend;
    pend = rd_en;
    @(posedge clk);
    #1;
    if (pend[0] && q0.size() != 0) void'(q0.pop_front());
    if (pend[1] && q1.size() != 0) void'(q1.pop_front());
    if (pend[2] && q2.size() != 0) void'(q2.pop_front());
    refresh();
    tx_tr.push_back(tx);
    rd_tr.push_back(rd_en);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_traces();
    tx_tr.delete();
    rd_tr.delete();
    exp_w.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ticks(2);
    rst = 1'b1;
  endtask

  task automatic add_level(input logic v);
    for (int i = 0; i < CPB; i++) exp_w.push_back(v);
  endtask

  // Frame with no parity and one stop bit.
  task automatic add_frame(input logic [7:0] b);
    add_level(1'b0);
    for (int i = 0; i < 8; i++) add_level(b[i]);
    add_level(1'b1);
  endtask

  function automatic int first_low(input int ch);
    for (int i = 0; i < tx_tr.size(); i++) if (tx_tr[i][ch] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_rd(input int ch);
    for (int i = 0; i < rd_tr.size(); i++) if (rd_tr[i][ch] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_rd(input int ch);
    int n = 0;
    for (int i = 0; i < rd_tr.size(); i++) if (rd_tr[i][ch] == 1'b1) n++;
    return n;
  endfunction

  // Compare the traced line from `start` against exp_w, then require idle-high afterwards.
  task automatic check_wave(input string tag, input int ch, input int start);
    int mism = 0;
    for (int k = 0; k < exp_w.size(); k++) begin
      if (start + k >= tx_tr.size()) mism++;
      else if (tx_tr[start + k][ch] !== exp_w[k]) mism++;
    end
    for (int i = start + exp_w.size(); i < tx_tr.size(); i++)
      if (tx_tr[i][ch] !== 1'b1) mism++;
    check(tag, mism, 0);
  endtask

  initial begin
    logic [11:0] c_bits;
    int pre_pops;

    rst = 1'b0;
    refresh();

    // Reset state, with a word already waiting on dut_a: reset must win.
    q0.push_back(32'h12345678);
    refresh();
    ticks(3);
    check("reset_tx", tx, 3'b111);
    check("reset_busy", busy, 3'b000);
    check("reset_rd_en", rd_en, 3'b000);
    check("reset_words_a", ws0, 16'h0000);
    check("reset_words_c", ws2, 16'h0000);
    q0.delete();
    refresh();
    rst = 1'b1;
    ticks(2);
    check("idle_tx", tx, 3'b111);

    // One word into every configuration at once.
    clear_traces();
    q0.push_back(32'hA1B2C3D4);
    q1.push_back(32'hA1B2C3D4);
    q2.push_back(8'h07);
    refresh();
    ticks(175);
    check("a_first_rd", first_rd(0), 0);
    check("a_start_idx", first_low(0), 1);
    check("b_start_idx", first_low(1), 1);
    check("c_start_idx", first_low(2), 1);
    add_frame(8'hD4); add_frame(8'hC3); add_frame(8'hB2); add_frame(8'hA1);
    check("a_len_160", exp_w.size(), 160);
    check_wave("a_wave_lsb_first", 0, 1);
    exp_w.delete();
    add_frame(8'hA1); add_frame(8'hB2); add_frame(8'hC3); add_frame(8'hD4);
    check_wave("b_wave_msb_first", 1, 1);
    exp_w.delete();
    c_bits = 12'b1100_0000_1110;
    for (int i = 0; i < 12; i++) add_level(c_bits[i]);
    check_wave("c_wave_odd_par_2stop", 2, 1);
    check("a_pops", count_rd(0), 1);
    check("b_pops", count_rd(1), 1);
    check("c_pops", count_rd(2), 1);
    check("a_words", ws0, 16'd1);
    check("b_words", ws1, 16'd1);
    check("c_words", ws2, 16'd1);
    check("end_busy", busy, 3'b000);

    // Two words back to back on dut_a: 2-cycle idle gap between them.
    do_reset();
    check("rst2_words", ws0, 16'd0);
    clear_traces();
    q0.push_back(32'h11223344);
    q0.push_back(32'h55667788);
    refresh();
    ticks(340);
    add_frame(8'h44); add_frame(8'h33); add_frame(8'h22); add_frame(8'h11);
    exp_w.push_back(1'b1); exp_w.push_back(1'b1);
    add_frame(8'h88); add_frame(8'h77); add_frame(8'h66); add_frame(8'h55);
    check_wave("a_two_words_gap", 0, 1);
    check("a_two_pops", count_rd(0), 2);
    check("a_two_words", ws0, 16'd2);

    // Reset mid-frame: byte 1 (0x0D), DATA bit 3 spans trace 57..60.
    do_reset();
    clear_traces();
    q0.push_back(32'h0F0E0D0C);
    q0.push_back(32'h44332211);
    refresh();
    ticks(59);
    check("abort_in_frame_busy", busy[0], 1'b1);
    pre_pops = count_rd(0);
    rst = 1'b0;
    tick();
    check("abort_tx", tx[0], 1'b1);
    check("abort_busy", busy[0], 1'b0);
    check("abort_words", ws0, 16'd0);
    ticks(2);
    check("abort_rd_held_low", rd_en[0], 1'b0);
    check("abort_pre_pops", pre_pops, 1);
    rst = 1'b1;
    clear_traces();
    ticks(170);
    check("resume_first_rd", first_rd(0), 0);
    check("resume_start_idx", first_low(0), 1);
    add_frame(8'h11); add_frame(8'h22); add_frame(8'h33); add_frame(8'h44);
    check_wave("resume_wave", 0, 1);
    check("resume_pops", count_rd(0), 1);
    check("resume_words", ws0, 16'd1);
    check("resume_fifo_drained", q0.size(), 0);

    // Counter wrap from 0xFFFF.
    do_reset();
    force dut_a.words_q = 16'hFFFF;
    tick();
    release dut_a.words_q;
    tick();
    check("wrap_preload", ws0, 16'hFFFF);
    clear_traces();
    q0.push_back(32'h00000000);
    refresh();
    ticks(170);
    check("wrap_words", ws0, 16'h0000);
    check("wrap_pops", count_rd(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
